// File: rtl/prince_mlayer_masked_iter.sv
// Iterative PRINCE M'/M/M^-1 linear layer on a d-share Boolean-masked state.
// COLS columns per share are mixed per cycle; each share is processed independently.
//   state | meaning
//   IDLE  | waiting for input, in_ready high
//   CALC  | mixing column groups of the working register in place
//   DONE  | result presented until out_ready
module prince_mlayer_masked_iter #(
    parameter int SHARES = 2,
    parameter int COLS   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [64*SHARES-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [64*SHARES-1:0]   out_data
);

    localparam int W = 64 * SHARES;
    localparam logic [1:0] STEP = 2'(COLS);
    localparam logic [1:0] LAST = 2'(4 - COLS);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_n;
    logic [1:0]    cnt, cnt_n;
    logic [1:0]    mode, mode_n;
    logic [W-1:0]  work, work_n;
    logic [W-1:0]  cap_val, step_val, sr_val;
    logic [15:0]   col      [SHARES][4];
    logic [15:0]   slot_out [SHARES][COLS];

    // Row r of M^1 equals row r+1 of M^0, so one mask table serves both.
    function automatic logic [15:0] mhat(input logic [15:0] x, input logic sel);
        logic [3:0] a, b, c, d, r0, r1, r2, r3;
        {a, b, c, d} = x;
        r0 = (a & 4'b0111) ^ (b & 4'b1011) ^ (c & 4'b1101) ^ (d & 4'b1110);
        r1 = (a & 4'b1011) ^ (b & 4'b1101) ^ (c & 4'b1110) ^ (d & 4'b0111);
        r2 = (a & 4'b1101) ^ (b & 4'b1110) ^ (c & 4'b0111) ^ (d & 4'b1011);
        r3 = (a & 4'b1110) ^ (b & 4'b0111) ^ (c & 4'b1011) ^ (d & 4'b1101);
        return sel ? {r1, r2, r3, r0} : {r0, r1, r2, r3};
    endfunction

    generate
        if (!(COLS == 1 || COLS == 2 || COLS == 4)) begin : g_bad_cols
            $error("prince_mlayer_masked_iter: COLS must be 1, 2 or 4");
        end

        for (genvar s = 0; s < SHARES; s++) begin : g_share
            localparam int B = 64 * s;

            for (genvar n = 0; n < 16; n++) begin : g_nib
                localparam int SRC_SR  = (5 * n) % 16;
                localparam int SRC_INV = (13 * n) % 16;
                assign cap_val[B+63-4*n -: 4] = (in_mode == 2'b10) ? in_data[B+63-4*SRC_INV -: 4]
                                                                   : in_data[B+63-4*n -: 4];
                assign sr_val[B+63-4*n -: 4]  = step_val[B+63-4*SRC_SR -: 4];
            end

            for (genvar c = 0; c < 4; c++) begin : g_col
                localparam logic [1:0] BASE = 2'(c - (c % COLS));
                localparam int SLOT = c % COLS;
                assign col[s][c] = work[B+63-16*c -: 16];
                assign step_val[B+63-16*c -: 16] = (cnt == BASE) ? slot_out[s][SLOT] : col[s][c];
            end

            // Columns 1 and 2 use M^1: their 2-bit index has exactly one bit set.
            for (genvar g = 0; g < COLS; g++) begin : g_slot
                logic [1:0] idx;
                assign idx = cnt + 2'(g);
                assign slot_out[s][g] = mhat(col[s][idx], idx[0] ^ idx[1]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            mode  <= 2'b00;
            work  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            mode  <= mode_n;
            work  <= work_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mode_n   = mode;
        work_n   = work;
        in_ready = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            CALC: begin
                work_n = (cnt == LAST && mode == 2'b01) ? sr_val : step_val;
                cnt_n  = cnt + STEP;
                if (cnt == LAST) state_n = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (in_valid && in_ready) begin
            mode_n  = in_mode;
            work_n  = cap_val;
            cnt_n   = 2'd0;
            state_n = (in_mode == 2'b11) ? DONE : CALC;
        end
    end

    assign out_valid = (state == DONE);
    assign out_data  = work;

endmodule

// File: tb/tb_prince_mlayer_masked_iter.sv
// Bench for prince_mlayer_masked_iter: three 2-share instances (COLS = 4, 2, 1)
// behind one selectable stimulus port, checked against a nibble-level reference model.
module tb_prince_mlayer_masked_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]   sel;
    logic         in_valid, out_ready;
    logic [1:0]   in_mode;
    logic [127:0] in_data;
    logic         in_ready, out_valid;
    logic [127:0] out_data;

    logic iv0, iv1, iv2, or0, or1, or2, ir0, ir1, ir2, ov0, ov1, ov2;
    logic [127:0] od0, od1, od2;

    assign iv0 = in_valid && sel == 2'd0;
    assign iv1 = in_valid && sel == 2'd1;
    assign iv2 = in_valid && sel == 2'd2;
    assign or0 = out_ready && sel == 2'd0;
    assign or1 = out_ready && sel == 2'd1;
    assign or2 = out_ready && sel == 2'd2;

    always_comb begin
        case (sel)
            2'd1:    begin in_ready = ir1; out_valid = ov1; out_data = od1; end
            2'd2:    begin in_ready = ir2; out_valid = ov2; out_data = od2; end
            default: begin in_ready = ir0; out_valid = ov0; out_data = od0; end
        endcase
    end

    prince_mlayer_masked_iter #(.SHARES(2), .COLS(4)) dut_c4 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov0), .out_ready(or0), .out_data(od0));
    prince_mlayer_masked_iter #(.SHARES(2), .COLS(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov1), .out_ready(or1), .out_data(od1));
    prince_mlayer_masked_iter #(.SHARES(2), .COLS(1)) dut_c1 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov2), .out_ready(or2), .out_data(od2));

    int checks   = 0;
    int failures = 0;

    // Reference: M-hat written straight from the XOR-of-three-nibbles rule.
    function automatic logic [63:0] ref_mprime(input logic [63:0] x);
        logic [63:0] y;
        int excl;
        logic acc;
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int p = 0; p < 4; p++) begin
                    excl = (p - r - ((c == 1 || c == 2) ? 1 : 0) + 8) % 4;
                    acc = 1'b0;
                    for (int q = 0; q < 4; q++)
                        if (q != excl) acc ^= 1'(x >> (63 - 16*c - 4*q - p));
                    y |= 64'(acc) << (63 - 16*c - 4*r - p);
                end
        return y;
    endfunction

    function automatic logic [63:0] ref_perm(input logic [63:0] x, input int mult);
        logic [63:0] y;
        int src;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            src = (mult * n) % 16;
            y |= 64'(4'(x >> (60 - 4*src))) << (60 - 4*n);
        end
        return y;
    endfunction

    function automatic logic [63:0] ref_op(input logic [1:0] mode, input logic [63:0] x);
        case (mode)
            2'b00:   return ref_mprime(x);
            2'b01:   return ref_perm(ref_mprime(x), 5);
            2'b10:   return ref_mprime(ref_perm(x, 13));
            default: return x;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 3 : 5);
    endfunction

    // Drives one transaction; latency counts edges from acceptance to the release edge.
    task automatic send(input int k, input logic [1:0] mode, input logic [127:0] data,
                        output int lat, output logic [127:0] res);
        int n;
        sel = 2'(k); in_mode = mode; in_data = data; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        lat = n + 1;
        res = out_data;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'b00; in_data = '0; sel = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            checks++;
            if (out_valid !== 1'b0 || out_data !== 128'h0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset k=%0d: out_valid=%b in_ready=%b out_data=%h, want 0/1/0",
                         k, out_valid, in_ready, out_data);
            end
        end
    endtask

    task automatic test_directed;
        int lat;
        logic [127:0] res, res2;
        send(0, 2'b00, 128'h1, lat, res);
        checks++;
        if (res !== 128'h111 || lat != 2) begin
            failures++;
            $display("FAIL mprime_lsb: got %h lat %0d, want %h lat 2", res, lat, 128'h111);
        end
        send(0, 2'b00, 128'h8000_0000_0000_0000, lat, res);
        checks++;
        if (res !== 128'h0888_0000_0000_0000) begin
            failures++;
            $display("FAIL mprime_msb: got %h, want %h", res, 128'h0888_0000_0000_0000);
        end
        for (int k = 0; k < 3; k++) begin
            send(k, 2'b01, 128'h1, lat, res);
            checks++;
            if (res !== 128'h0001_0010_0100_0000 || lat != lat_of(k)) begin
                failures++;
                $display("FAIL m_fwd k=%0d: got %h lat %0d, want %h lat %0d",
                         k, res, lat, 128'h0001_0010_0100_0000, lat_of(k));
            end
            send(k, 2'b10, res, lat, res2);
            checks++;
            if (res2 !== 128'h1 || lat != lat_of(k)) begin
                failures++;
                $display("FAIL m_inv k=%0d: got %h lat %0d, want 1 lat %0d", k, res2, lat, lat_of(k));
            end
        end
    endtask

    task automatic test_bypass;
        int lat;
        logic [127:0] d, res;
        for (int k = 0; k < 3; k++) begin
            d = {$urandom(), $urandom(), 64'hDEAD_BEEF_0123_4567};
            send(k, 2'b11, d, lat, res);
            checks++;
            if (res !== d || lat != 1) begin
                failures++;
                $display("FAIL bypass k=%0d: got %h lat %0d, want %h lat 1", k, res, lat, d);
            end
        end
    endtask

    task automatic test_random;
        int lat, k;
        logic [63:0] x, m;
        logic [1:0] mode;
        logic [127:0] res, res2;
        for (int i = 0; i < 1000; i++) begin
            k = i % 3;
            x = {$urandom(), $urandom()};
            m = {$urandom(), $urandom()};
            mode = (i % 4 == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            send(k, mode, {m, x ^ m}, lat, res);
            checks++;
            if ((res[63:0] ^ res[127:64]) !== ref_op(mode, x)) begin
                failures++;
                $display("FAIL rand_unmasked i=%0d mode=%0d: got %h, want %h",
                         i, mode, res[63:0] ^ res[127:64], ref_op(mode, x));
            end
            checks++;
            if (res[127:64] !== ref_op(mode, m)) begin
                failures++;
                $display("FAIL rand_share1 i=%0d mode=%0d: got %h, want %h",
                         i, mode, res[127:64], ref_op(mode, m));
            end
            checks++;
            if (lat != ((mode == 2'b11) ? 1 : lat_of(k))) begin
                failures++;
                $display("FAIL rand_latency i=%0d k=%0d mode=%0d: got %0d", i, k, mode, lat);
            end
            if (i % 50 == 1 && mode == 2'b00) begin
                send(k, 2'b00, res, lat, res2);
                checks++;
                if (res2 !== {m, x ^ m}) begin
                    failures++;
                    $display("FAIL involution i=%0d: got %h, want %h", i, res2, {m, x ^ m});
                end
            end
        end
    endtask

    task automatic test_mode_toggle;
        int n;
        logic [127:0] d, exp_d;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_d = {ref_op(2'b01, d[127:64]), ref_op(2'b01, d[63:0])};
        sel = 2'd2; in_mode = 2'b01; in_data = d; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            in_mode = 2'($urandom());
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_d) begin
            failures++;
            $display("FAIL mode_toggle: valid=%b got %h, want %h", out_valid, out_data, exp_d);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [127:0] a, b, exp_a, exp_b;
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_a = {ref_op(2'b00, a[127:64]), ref_op(2'b00, a[63:0])};
        exp_b = {ref_op(2'b01, b[127:64]), ref_op(2'b01, b[63:0])};
        sel = 2'd0; in_mode = 2'b00; in_data = a; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_data = b; in_mode = 2'b01;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_a || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure cyc=%0d: valid=%b ready=%b got %h, want 1/0 %h",
                         i, out_valid, in_ready, out_data, exp_a);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: in_ready=%b, want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_release: out_valid=%b, want 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_b) begin
            failures++;
            $display("FAIL b2b_next: valid=%b got %h, want 1 %h", out_valid, out_data, exp_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid;
        int n, lat;
        logic stale;
        logic [127:0] d, res;
        sel = 2'd2; in_mode = 2'b00; in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid: valid=%b ready=%b data=%h, want 0/1/0", out_valid, in_ready, out_data);
        end
        stale = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("FAIL rst_stale: out_valid seen after abort=%b, want 0", stale);
        end
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(2, 2'b00, d, lat, res);
        checks++;
        if (res !== {ref_op(2'b00, d[127:64]), ref_op(2'b00, d[63:0])} || lat != 5) begin
            failures++;
            $display("FAIL rst_recover: got %h lat %0d, want %h lat 5",
                     res, lat, {ref_op(2'b00, d[127:64]), ref_op(2'b00, d[63:0])});
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_bypass();
        test_random();
        test_mode_toggle();
        test_back_to_back();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
